// File: rtl/fetch_unit_pkg.sv
// Shared types for the MINAv2 fetch stage.
package types;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam pc_t PC_STEP = 32'd4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; flush beats push/pop.
module fetch_buffer
  import types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head reads as zero when empty so the stage outputs are clean after reset/flush.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// MINAv2 fetch stage: PC, single-outstanding imem requests, instruction buffer.
module fetch_unit
  import types::*;
#(
  parameter pc_t RESET_PC  = 32'h0000_0000,
  parameter int  BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_hazard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  pc_t           fetch_pc;
  pc_t           req_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  din;
  logic          xfer;
  logic          push;
  logic          pop;

  // Only issue when a slot is guaranteed: with one request in flight, count < depth suffices.
  assign imem_req  = ~rst & (state_q == FETCH_REQ) & (count < CW'(BUF_DEPTH));
  assign imem_addr = fetch_pc;
  assign xfer      = imem_req & imem_gnt;

  assign push = (state_q == FETCH_WAIT) & imem_rvalid & ~redirect_valid;
  assign pop  = if_valid & ~load_hazard & ~redirect_valid;
  assign din  = '{pc: req_pc, instr: imem_rdata};

  // Next state: a redirect while a request is in flight turns its response into a discard.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_REQ:  if (xfer) state_d = redirect_valid ? FETCH_DROP : FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_rvalid)         state_d = FETCH_REQ;
        else if (redirect_valid) state_d = FETCH_DROP;
      end
      FETCH_DROP: if (imem_rvalid) state_d = FETCH_REQ;
      default:    state_d = FETCH_REQ;
    endcase
  end

  // FSM and PC registers; redirect target wins over the sequential increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) req_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (xfer)
        fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign if_valid = (count != '0);
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Random-stimulus bench for fetch_unit with a queue-based stream model.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_hazard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_hazard    (load_hazard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;

  // Model: delivered-but-unconsumed instructions, next address to request,
  // one in-flight memory transaction tagged with the redirect epoch it was issued in.
  ent_t        q[$];
  logic [31:0] issue_pc;
  bit          outst;
  int          lat;
  logic [31:0] resp_pc;
  int          resp_ep;
  int          epoch;
  int          hz_left;
  logic [31:0] targets [5] = '{32'h0000_2002, 32'h0000_0040, 32'hFFFF_FFFC,
                               32'hFFFF_FFF8, 32'h0000_0103};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    issue_pc = RPC;
    outst    = 0;
    lat      = 0;
    epoch    = 0;
    hz_left  = 0;
  endtask

  // Hold reset for two edges and check the reset-state outputs.
  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    load_hazard    = 1'b0;
    #1 chk("req_in_rst", imem_req, 0);
    @(negedge clk);
    #1;
    chk("rst_req",    imem_req, 0);
    chk("rst_valid",  if_valid, 0);
    chk("rst_pc",     if_pc,    0);
    chk("rst_instr",  if_instr, 0);
    model_reset();
  endtask

  // One clock: drive inputs at negedge, check outputs, then advance the model across the edge.
  task automatic step();
    bit          exp_req;
    bit          xfer;
    bit          pop;
    int          cur_ep;
    logic [31:0] old_issue;
    @(negedge clk);
    rst = 1'b0;
    if (hz_left == 0 && $urandom_range(0, 9) == 0) hz_left = $urandom_range(1, 8);
    load_hazard = (hz_left > 0);
    if (hz_left > 0) hz_left--;
    redirect_valid = ($urandom_range(0, 19) == 0);
    redirect_pc    = ($urandom_range(0, 5) == 5) ? $urandom : targets[$urandom_range(0, 4)];
    imem_gnt       = ($urandom_range(0, 3) != 0);
    imem_rdata     = $urandom;
    imem_rvalid    = 1'b0;
    if (outst) begin
      lat--;
      if (lat == 0) imem_rvalid = 1'b1;
    end
    #1;
    exp_req = !outst && (q.size() < DEPTH);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, issue_pc);
    chk("if_valid", if_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("if_pc",    if_pc,    q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
    end

    xfer      = exp_req && imem_gnt;
    pop       = (q.size() != 0) && !load_hazard && !redirect_valid;
    cur_ep    = epoch;
    old_issue = issue_pc;
    if (pop) void'(q.pop_front());
    if (imem_rvalid) begin
      outst = 0;
      if (!redirect_valid && resp_ep == epoch) q.push_back('{resp_pc, imem_rdata});
    end
    if (redirect_valid) begin
      q.delete();
      epoch++;
      issue_pc = {redirect_pc[31:2], 2'b00};
    end
    if (xfer) begin
      outst   = 1;
      lat     = $urandom_range(1, 3);
      resp_pc = old_issue;
      resp_ep = cur_ep;
      if (!redirect_valid) issue_pc = old_issue + 32'd4;
    end
  endtask

  initial begin
    rst            = 1'b1;
    load_hazard    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-address (IA) / fetch stage of the MINAv2 pipeline, directly upstream of the IF/ID register and the decode stage that raises `load_hazard`. It holds the fetch PC, issues one-outstanding requests to instruction memory, and buffers returned instructions in a small FIFO. It presents them to IF/ID with a valid flag, holds the head instruction while `load_hazard` is asserted, and flushes on a branch/jump redirect from EX.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be zero.
- `BUF_DEPTH`, default 2: instruction buffer entries; legal values are 2 or 4.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_hazard`  in  1  stall from the hazard unit; while high, the head entry is not consumed.
- `redirect_valid`  in  1  taken branch/jump from EX.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as zero.
- `imem_req`  out  1  request valid, address phase.
- `imem_addr`  out  32  request address, word aligned.
- `imem_gnt`  in  1  address accepted this cycle; a transfer occurs when `imem_req` and `imem_gnt` are both high.
- `imem_rvalid`  in  1  read data valid; arrives 1 or more cycles after the grant.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  buffer head is valid for IF/ID.
- `if_pc`  out  32  PC of the head instruction.
- `if_instr`  out  32  head instruction word.

## Operation
- State machine `fetch_state_e` has three states:
  - REQ: `imem_req` is high when `count + 0 < BUF_DEPTH`, with `imem_addr = fetch_pc`. On grant, `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, and the FSM moves to WAIT.
  - WAIT: `imem_req` is low. On `imem_rvalid`, push {`req_pc`, `imem_rdata`} and move to REQ.
  - DROP: `imem_req` is low. On `imem_rvalid`, discard the data and move to REQ.
- At most one request is outstanding. A request is issued only if a free slot is guaranteed, so the buffer never overflows.
- Pop occurs when `if_valid && !load_hazard && !redirect_valid`.
- Redirect has the highest priority. In the cycle of `redirect_valid`:
  - the buffer is flushed (count to 0);
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`;
  - no push occurs.
- Redirect state transitions:
  - In WAIT without `imem_rvalid`: move to DROP.
  - In WAIT with `imem_rvalid` in the same cycle: drop the data and move to REQ.
  - In REQ with a grant in the same cycle: the granted stale request moves the FSM to DROP. `fetch_pc` takes the redirect target, not +4.
  - In DROP: stay in DROP until `imem_rvalid`. A second redirect updates `fetch_pc` only.
- Push and pop in the same cycle: count is unchanged and FIFO order is preserved.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `load_hazard` does not gate `imem_req`; only buffer space does.

## Timing
- Reset values: state=REQ, `fetch_pc=RESET_PC`, count=0, `if_valid=0`, `imem_req=0` during reset; `if_pc` and `if_instr` are 0.
- First cycle after `rst` falls: `imem_req=1` with `imem_addr=RESET_PC`.
- Latency:
  - `imem_rvalid` in cycle N: `if_valid=1` in cycle N+1 (registered, no bypass).
  - Grant in N with `imem_rvalid` in N+1: the next request is issued in N+2.
- Throughput is one instruction per 2 cycles with 1-cycle memory.
- `if_valid` falls in the cycle after a redirect. The first post-redirect request is issued in that cycle if the FSM is in REQ.
- `rst` asserted mid-operation: all state returns to reset values at the next edge. An outstanding `imem_rvalid` arriving after reset is ignored only if it arrives while `rst` is high. Memory must be reset together with this block.

## Structure
- Shared package `types`: `pc_t` (logic [31:0]), `instr_t` (logic [31:0]), `fetch_state_e` {FETCH_REQ, FETCH_WAIT, FETCH_DROP}, `PC_STEP = 4`.
- Sub-module `fetch_buffer`:
  - synchronous FIFO of {`pc_t`, `instr_t`} with parameter `DEPTH`;
  - ports `push`, `pop`, `flush`, `count`, `head`;
  - `flush` has priority over `push` and `pop`.
- `fetch_unit` contains the FSM, the `fetch_pc`/`req_pc` registers and the `fetch_buffer` instance.

## Test plan
- Reset release with `RESET_PC`=0x100 and 1-cycle memory returning 0xA0+addr: `if_pc` sequence is 0x100, 0x104, 0x108, and `if_instr` matches.
- `load_hazard` high for 6 cycles with BUF_DEPTH=2:
  - the buffer fills to 2;
  - `imem_req` stays low while full;
  - the head stays 0x104 throughout;
  - after release, order 0x104, 0x108 is intact with no loss or duplication.
- Redirect to 0x2002 while in WAIT, with rvalid 3 cycles later:
  - the returned word is dropped;
  - the next `imem_addr` is 0x2000;
  - `if_valid` stays 0 until 0x2000 data arrives.
- Redirect in the same cycle as a grant for 0x108, targeting 0x40: FSM enters DROP, the stale response is discarded, and the next request is 0x40.
- `fetch_pc` = 0xFFFF_FFFC: the next request is 0x0000_0000.
- Same-cycle push and pop with count=1: count stays 1 and `if_pc` advances by 4.
